// File: rtl/pio_bank_ctrl.sv
// rtl/pio_bank_ctrl.sv - banked PIO controller with per-bank direction turnaround sequencing
// Optional per-bit edge interrupts are built when PIO_EDGE_IRQ_EN is defined.
module pio_bank_ctrl #(
    parameter int NUM_BANKS   = 6,
    parameter int BANK_WIDTH  = 8,
    parameter int TURN_CYCLES = 4
) (
    input  logic                            SYS_CLK,
    input  logic                            SYS_RST_N,
    input  logic                            REG_WR,
    input  logic                            REG_RD,
    input  logic [5:0]                      REG_ADDR,
    input  logic [31:0]                     REG_WDATA,
    output logic [31:0]                     REG_RDATA,
    output logic                            REG_RVALID,
    input  logic [NUM_BANKS*BANK_WIDTH-1:0] PIO_IN,
    output logic [NUM_BANKS*BANK_WIDTH-1:0] PIO_OUT,
    output logic [NUM_BANKS-1:0]            PIO_DIR,
    output logic [NUM_BANKS-1:0]            PIO_OE_B,
    output logic                            PIO_IRQ
);
    localparam int PW = NUM_BANKS * BANK_WIDTH;
    localparam int CW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TURN_CYCLES - 1);

    localparam logic [1:0] REG_DATA_OUT = 2'd0;
    localparam logic [1:0] REG_DATA_IN  = 2'd1;
    localparam logic [1:0] REG_DIR      = 2'd2;
    localparam logic [1:0] REG_IRQ      = 2'd3;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_OFF1, SEQ_SWAP, SEQ_OFF2} seq_state_e;

    logic [3:0] addr_bank;
    logic [1:0] addr_reg;
    assign addr_bank = REG_ADDR[5:2];
    assign addr_reg  = REG_ADDR[1:0];

    logic [PW-1:0]        sync1_q, sync2_q;
    logic [PW-1:0]        data_out_q, data_out_d;
    logic [NUM_BANKS-1:0] target_q, target_d;
    logic [NUM_BANKS-1:0] dir_q, dir_d;
    logic [NUM_BANKS-1:0] oe_b_q, oe_b_d;
    seq_state_e           state_q [NUM_BANKS];
    seq_state_e           state_d [NUM_BANKS];
    logic [CW-1:0]        cnt_q [NUM_BANKS];
    logic [CW-1:0]        cnt_d [NUM_BANKS];
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q;
    logic [PW-1:0]        irq_status;

    logic unused_wdata;
    assign unused_wdata = ^REG_WDATA;

    always_comb begin
        data_out_d = data_out_q;
        target_d   = target_q;
        dir_d      = dir_q;
        oe_b_d     = oe_b_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (addr_bank == 4'(b)) begin
                if (REG_WR && addr_reg == REG_DATA_OUT)
                    data_out_d[b*BANK_WIDTH +: BANK_WIDTH] = REG_WDATA[BANK_WIDTH-1:0];
                if (REG_WR && addr_reg == REG_DIR)
                    target_d[b] = REG_WDATA[0];
                if (REG_RD) begin
                    case (addr_reg)
                        REG_DATA_OUT: rdata_d = 32'(data_out_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        REG_DATA_IN:  rdata_d = 32'(sync2_q[b*BANK_WIDTH +: BANK_WIDTH]);
                        REG_DIR:      rdata_d = {30'd0, oe_b_q[b], target_q[b]};
                        default:      rdata_d = 32'(irq_status[b*BANK_WIDTH +: BANK_WIDTH]);
                    endcase
                end
            end

            // A sequence only ever flips the direction; later target changes are caught on the way out.
            case (state_q[b])
                SEQ_IDLE: begin
                    if (target_d[b] != dir_q[b]) begin
                        state_d[b] = SEQ_OFF1;
                        cnt_d[b]   = '0;
                    end
                end
                SEQ_OFF1: begin
                    if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = SEQ_SWAP;
                        dir_d[b]   = ~dir_q[b];
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                SEQ_SWAP: begin
                    state_d[b] = SEQ_OFF2;
                    cnt_d[b]   = '0;
                end
                default: begin
                    if (cnt_q[b] == CNT_LAST)
                        state_d[b] = SEQ_IDLE;
                    else
                        cnt_d[b] = cnt_q[b] + 1'b1;
                end
            endcase
            // Keeping OE off while target and direction disagree holds the bank dark across a re-run.
            oe_b_d[b] = (state_d[b] != SEQ_IDLE) || (target_d[b] != dir_d[b]);
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            data_out_q <= '0;
            target_q   <= '0;
            dir_q      <= '0;
            oe_b_q     <= '0;
            state_q    <= '{default: SEQ_IDLE};
            cnt_q      <= '{default: '0};
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            sync1_q    <= PIO_IN;
            sync2_q    <= sync1_q;
            data_out_q <= data_out_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            oe_b_q     <= oe_b_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= REG_RD;
        end
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [PW-1:0] sync3_q;
    logic [PW-1:0] mask_q, mask_d;
    logic [PW-1:0] status_q, status_d;
    logic          irq_q, irq_d;

    always_comb begin
        mask_d   = mask_q;
        status_d = status_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (REG_WR && addr_reg == REG_IRQ && addr_bank == 4'(b)) begin
                if (REG_WDATA[31])
                    mask_d[b*BANK_WIDTH +: BANK_WIDTH] = REG_WDATA[BANK_WIDTH-1:0];
                else
                    status_d[b*BANK_WIDTH +: BANK_WIDTH] =
                        status_q[b*BANK_WIDTH +: BANK_WIDTH] & ~REG_WDATA[BANK_WIDTH-1:0];
            end
            // Applied after the clear so a coincident edge wins.
            if (!dir_q[b])
                status_d[b*BANK_WIDTH +: BANK_WIDTH] = status_d[b*BANK_WIDTH +: BANK_WIDTH] |
                    (sync2_q[b*BANK_WIDTH +: BANK_WIDTH] & ~sync3_q[b*BANK_WIDTH +: BANK_WIDTH]);
        end
        irq_d = |(status_q & mask_q);
    end

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            sync3_q  <= '0;
            mask_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync3_q  <= sync2_q;
            mask_q   <= mask_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_status = status_q;
    assign PIO_IRQ    = irq_q;
`else
    assign irq_status = '0;
    assign PIO_IRQ    = 1'b0;
`endif

    assign PIO_OUT    = data_out_q;
    assign PIO_DIR    = dir_q;
    assign PIO_OE_B   = oe_b_q;
    assign REG_RDATA  = rdata_q;
    assign REG_RVALID = rvalid_q;

endmodule
